// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: engine op codes and arbiter FSM states.
package mem_port_arbiter_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Op 2'b10 is illegal and never counts as a request.
  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module mem_port_arbiter_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ engines, one transaction per grant.
// Optional WAIT timeout enabled by defining ARB_TIMEOUT_EN; DATA_W defaults from TYPE_BW.
`ifndef TYPE_BW
`define TYPE_BW 32
`endif

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = `TYPE_BW,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2*NUM_REQ-1:0]      req_op_i,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr_i,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_opdone_o,
  output logic [DATA_W-1:0]         req_rdata_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [1:0]                mem_op_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic                      mem_opdone_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     gidx_q, gidx_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [1:0]          mem_op_q, mem_op_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [NUM_REQ-1:0]  req_valid;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;
  logic                timeout_hit;
  logic                done_hit;

  always_comb begin
    req_valid = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_valid[r] = op_valid(req_op_i[2*r +: 2]);
    end
  end

  mem_port_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] tmo_cnt_q;
  logic            err_q;

  assign timeout_hit = (state_q == ST_WAIT) && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Counter idles at zero outside WAIT, so it is already clear on WAIT entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q != ST_WAIT) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (timeout_hit && !mem_opdone_i) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign err_o          = 1'b0;
`endif

  assign done_hit = (state_q == ST_WAIT) && (mem_opdone_i || timeout_hit);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_WAIT;
          grant_d     = pick_gnt;
          gidx_d      = pick_idx;
          mem_op_d    = req_op_i[2*pick_idx +: 2];
          mem_addr_d  = req_addr_i[ADDR_W*pick_idx +: ADDR_W];
          mem_wdata_d = req_wdata_i[DATA_W*pick_idx +: DATA_W];
        end
      end
      ST_WAIT: begin
        if (mem_opdone_i || timeout_hit) begin
          state_d  = ST_RELEASE;
          grant_d  = '0;
          mem_op_d = OP_NONE;
        end
      end
      ST_RELEASE: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      mem_op_q    <= OP_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Done and read data leave together so the engine samples both in one cycle.
  assign req_opdone_o = done_hit ? grant_q : '0;
  assign req_rdata_o  = (timeout_hit && !mem_opdone_i) ? '0 : mem_rdata_i;
  assign grant_o      = grant_q;
  assign mem_op_o     = mem_op_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
